// File: rtl/cmp_arb_pkg.sv
// Shared encodings for the compare arbiter: ALUC ops, FSM states, requester IDs
// and the round-robin pick used for the grant.
package cmp_arb_pkg;

  localparam logic [1:0] ALUC_LUI  = 2'b00;
  localparam logic [1:0] ALUC_SLTU = 2'b10;
  localparam logic [1:0] ALUC_SLT  = 2'b11;

  localparam logic REQ_EXE = 1'b0;
  localparam logic REQ_BR  = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // A lone requester wins; on contention the one not granted last time wins.
  function automatic logic [1:0] rr_pick(input logic [1:0] valid, input logic last);
    logic [1:0] pick;
    pick = 2'b00;
    case (valid)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      2'b11:   pick = (last == REQ_BR) ? 2'b01 : 2'b10;
      default: pick = 2'b00;
    endcase
    return pick;
  endfunction

endpackage

// File: rtl/cmp_core.sv
// Combinational LUI/SLT/SLTU slice; eq and lt are produced for every op.
module cmp_core (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [1:0]  aluc,
  output logic [31:0] r,
  output logic        eq,
  output logic        lt
);

  always_comb begin
    eq = (a == b);
    lt = aluc[0] ? ($signed(a) < $signed(b)) : (a < b);
    r  = aluc[1] ? {31'b0, lt} : {b[15:0], 16'h0};
  end

endmodule

// File: rtl/cmp_arbiter.sv
// Round-robin share of cmp_core between execute (0) and branch-resolve (1), one
// registered tagged response channel. CMP_ARB_PIPE_EN allows a grant while the response drains.
module cmp_arbiter
  import cmp_arb_pkg::*;
#(
  parameter int ID_W = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [31:0]     req_a0,
  input  logic [31:0]     req_a1,
  input  logic [31:0]     req_b0,
  input  logic [31:0]     req_b1,
  input  logic [1:0]      req_aluc0,
  input  logic [1:0]      req_aluc1,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [31:0]     rsp_r,
  output logic            rsp_eq,
  output logic            rsp_lt,
  output logic [ID_W-1:0] rsp_id
);

  state_e          state_q, state_d;
  logic            last_grant_q, last_grant_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [31:0]     rsp_r_q, rsp_r_d;
  logic            rsp_eq_q, rsp_eq_d;
  logic            rsp_lt_q, rsp_lt_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;

  logic        can_grant;
  logic        xfer;
  logic        gnt_id;
  logic [31:0] mux_a, mux_b;
  logic [1:0]  mux_aluc;
  logic [31:0] core_r;
  logic        core_eq, core_lt;

  // Grant depends only on valids, state and last_grant, never on operands.
  always_comb begin
`ifdef CMP_ARB_PIPE_EN
    can_grant = (state_q == IDLE) || rsp_ready;
`else
    can_grant = (state_q == IDLE);
`endif
    req_ready = can_grant ? rr_pick(req_valid, last_grant_q) : 2'b00;
    xfer      = |(req_valid & req_ready);
    gnt_id    = req_ready[1];
    mux_a     = (gnt_id == REQ_BR) ? req_a1    : req_a0;
    mux_b     = (gnt_id == REQ_BR) ? req_b1    : req_b0;
    mux_aluc  = (gnt_id == REQ_BR) ? req_aluc1 : req_aluc0;
  end

  cmp_core u_core (
    .a    (mux_a),
    .b    (mux_b),
    .aluc (mux_aluc),
    .r    (core_r),
    .eq   (core_eq),
    .lt   (core_lt)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_r_d      = rsp_r_q;
    rsp_eq_d     = rsp_eq_q;
    rsp_lt_d     = rsp_lt_q;
    rsp_id_d     = rsp_id_q;
    if (state_q == BUSY && rsp_ready) begin
      state_d     = IDLE;
      rsp_valid_d = 1'b0;
    end
    // xfer is only possible in BUSY when the response is draining this cycle.
    if (xfer) begin
      state_d      = BUSY;
      rsp_valid_d  = 1'b1;
      last_grant_d = gnt_id;
      rsp_r_d      = core_r;
      rsp_eq_d     = core_eq;
      rsp_lt_d     = core_lt;
      rsp_id_d     = ID_W'(gnt_id);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= REQ_BR;
      rsp_valid_q  <= 1'b0;
      rsp_r_q      <= 32'h0;
      rsp_eq_q     <= 1'b0;
      rsp_lt_q     <= 1'b0;
      rsp_id_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_r_q      <= rsp_r_d;
      rsp_eq_q     <= rsp_eq_d;
      rsp_lt_q     <= rsp_lt_d;
      rsp_id_q     <= rsp_id_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_r     = rsp_r_q;
  assign rsp_eq    = rsp_eq_q;
  assign rsp_lt    = rsp_lt_q;
  assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_cmp_arbiter.sv
// Bench for cmp_arbiter: per-cycle reference model plus directed hand-computed vectors.
module tb_cmp_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [31:0] req_a0 = 0, req_a1 = 0, req_b0 = 0, req_b1 = 0;
  logic [1:0]  req_aluc0 = 0, req_aluc1 = 0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_r;
  logic        rsp_eq, rsp_lt;
  logic [0:0]  rsp_id;

  int n_cmp = 0;
  int n_fail = 0;

  cmp_arbiter #(.ID_W(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
    .req_aluc0(req_aluc0), .req_aluc1(req_aluc1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_r(rsp_r), .rsp_eq(rsp_eq), .rsp_lt(rsp_lt), .rsp_id(rsp_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result from the arithmetic meaning of each op.
  function automatic void ref_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] c,
                                 output logic [31:0] r, output logic eq, output logic lt);
    longint sa, sb;
    sa = c[0] ? longint'($signed(a)) : longint'({32'b0, a});
    sb = c[0] ? longint'($signed(b)) : longint'({32'b0, b});
    eq = (a == b);
    lt = (sa < sb);
    r  = c[1] ? (lt ? 32'd1 : 32'd0) : (32'(b[15:0]) * 32'd65536);
  endfunction

  // Model state: whether a response is outstanding, its contents, who was served last.
  logic        m_busy = 1'b0;
  logic        m_last = 1'b1;
  logic [31:0] m_r = 0;
  logic        m_eq = 0, m_lt = 0, m_id = 0;
  logic        pipe_en;
  logic        obs_ids [$];

  initial begin
`ifdef CMP_ARB_PIPE_EN
    pipe_en = 1'b1;
`else
    pipe_en = 1'b0;
`endif
  end

  always @(negedge clk) begin
    logic [1:0]  exp_rdy;
    logic        id;
    logic [31:0] r;
    logic        eq, lt;
    if (!rst_n) begin
      m_busy = 1'b0;
      m_last = 1'b1;
      chk("rst_req_ready", {30'b0, req_ready}, 32'd0);
      chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("rst_rsp_r", rsp_r, 32'd0);
      chk("rst_rsp_flags", {29'b0, rsp_eq, rsp_lt, rsp_id}, 32'd0);
    end else begin
      exp_rdy = 2'b00;
      if (!m_busy || (pipe_en && rsp_ready)) begin
        if (req_valid == 2'b01) exp_rdy = 2'b01;
        else if (req_valid == 2'b10) exp_rdy = 2'b10;
        else if (req_valid == 2'b11) exp_rdy = m_last ? 2'b01 : 2'b10;
      end
      chk("m_req_ready", {30'b0, req_ready}, {30'b0, exp_rdy});
      chk("m_rsp_valid", {31'b0, rsp_valid}, {31'b0, m_busy});
      if (m_busy) begin
        chk("m_rsp_r", rsp_r, m_r);
        chk("m_rsp_flags", {29'b0, rsp_eq, rsp_lt, rsp_id}, {29'b0, m_eq, m_lt, m_id});
        if (rsp_ready) obs_ids.push_back(rsp_id[0]);
      end
      if (m_busy && rsp_ready) m_busy = 1'b0;
      if (|(req_valid & exp_rdy)) begin
        id = exp_rdy[1];
        if (id) ref_op(req_a1, req_b1, req_aluc1, r, eq, lt);
        else    ref_op(req_a0, req_b0, req_aluc0, r, eq, lt);
        m_busy = 1'b1; m_last = id; m_id = id;
        m_r = r; m_eq = eq; m_lt = lt;
      end
    end
  end

  task automatic drive(input logic id, input logic [31:0] a, input logic [31:0] b, input logic [1:0] c);
    if (id) begin req_a1 = a; req_b1 = b; req_aluc1 = c; end
    else    begin req_a0 = a; req_b0 = b; req_aluc0 = c; end
    req_valid[id] = 1'b1;
  endtask

  // Issue on one requester; returns after the transfer edge with valid dropped.
  task automatic send(input logic id, input logic [31:0] a, input logic [31:0] b, input logic [1:0] c);
    logic done;
    done = 1'b0;
    drive(id, a, b, c);
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (req_ready[id]) done = 1'b1;
    end
    chk("send_granted", {31'b0, done}, 32'd1);
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
    chk("latency_rsp_valid", {31'b0, rsp_valid}, 32'd1);
  endtask

  task automatic take(input string name, input logic [31:0] r, input logic eq, input logic lt, input logic id);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid) got = 1'b1;
    end
    chk({name, "_seen"}, {31'b0, got}, 32'd1);
    chk({name, "_r"}, rsp_r, r);
    chk({name, "_eq_lt_id"}, {29'b0, rsp_eq, rsp_lt, rsp_id}, {29'b0, eq, lt, id});
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  typedef struct {
    logic        id;
    logic [31:0] a, b;
    logic [1:0]  c;
    logic [31:0] r;
    logic        eq, lt;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{1'b0, 32'h0000_0000, 32'h0000_1234, 2'b00, 32'h1234_0000, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 2'b11, 32'h0000_0001, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 2'b10, 32'h0000_0000, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 2'b01, 32'h0001_0000, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 32'h0000_0007, 32'h0000_0007, 2'b11, 32'h0000_0000, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 2'b11, 32'h0000_0001, 1'b0, 1'b1};

    repeat (2) @(negedge clk);
    chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      send(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].c);
      take($sformatf("vec%0d", i), vecs[i].r, vecs[i].eq, vecs[i].lt, vecs[i].id);
    end

    send(1'b0, 32'd5, 32'd5, 2'b10);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_r", rsp_r, 32'd0);
      chk("bp_flags", {29'b0, rsp_valid, rsp_eq, rsp_lt}, 32'b110);
      chk("bp_req_ready", {30'b0, req_ready}, 32'd0);
    end
    take("bp", 32'd0, 1'b1, 1'b0, 1'b0);

    send(1'b1, 32'd3, 32'd9, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("async_rst_rsp_r", rsp_r, 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    obs_ids.delete();
    rsp_ready = 1'b1;
    drive(1'b0, 32'd1, 32'd2, 2'b11);
    drive(1'b1, 32'd3, 32'd2, 2'b10);
    for (int i = 0; i < 30 && obs_ids.size() < 4; i++) @(posedge clk);
    #1;
    req_valid = 2'b00;
    chk("contention_count", {31'b0, obs_ids.size() >= 4}, 32'd1);
    if (obs_ids.size() >= 4) begin
      chk("contention_id0", {31'b0, obs_ids[0]}, 32'd0);
      chk("contention_id1", {31'b0, obs_ids[1]}, 32'd1);
      chk("contention_id2", {31'b0, obs_ids[2]}, 32'd0);
      chk("contention_id3", {31'b0, obs_ids[3]}, 32'd1);
    end
    repeat (3) @(posedge clk); #1;
    rsp_ready = 1'b0;

`ifdef CMP_ARB_PIPE_EN
    rsp_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0000_BEEF, 2'b00);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("pipe_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      chk("pipe_rsp_r", rsp_r, 32'hBEEF_0000);
    end
    req_valid = 2'b00;
    repeat (2) @(posedge clk); #1;
    rsp_ready = 1'b0;
`endif

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cmp_arbiter.md
# cmp_arbiter

Shares the single LUI/SLT/SLTU compare datapath between two requesters: requester 0 is the execute stage, requester 1 is the branch-resolve logic. Requests arrive on valid/ready handshakes. A round-robin arbiter grants one request at a time. Each result is registered and returned on one shared response channel, tagged with the requester ID. The block sits beside the ALU in the execute stage and replaces direct instantiation of the compare unit by each consumer.

## Interface
- `ID_W`, default 1: response tag width. Fixed at 1 for two requesters.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 2: per-requester request valid; bit i belongs to requester i.
- `req_ready` out 2: per-requester accept; a transfer occurs when `req_valid[i] & req_ready[i]`.
- `req_a0`, `req_a1` in 32: operand a, one port per requester.
- `req_b0`, `req_b1` in 32: operand b, one port per requester.
- `req_aluc0`, `req_aluc1` in 2: operation select. bit1=1 selects set-less-than; bit1=0 selects LUI. bit0=1 makes the compare signed; bit0=0 makes it unsigned.
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_r` out 32: result word.
- `rsp_eq` out 1: a == b.
- `rsp_lt` out 1: a < b, with signedness given by aluc bit0.
- `rsp_id` out ID_W: ID of the requester the response belongs to.

## Operation
- State machine `IDLE`, `BUSY`.
- `IDLE`:
  - `req_ready` is one-hot to the granted requester, or 0 when no request is pending.
  - Grant rule: a lone valid requester wins. When both are valid, the requester not equal to `last_grant` wins.
  - On a transfer: latch the result, flags and ID; update `last_grant`; go to `BUSY`.
- `BUSY`:
  - `rsp_valid`=1. Outputs hold stable until `rsp_ready`=1.
  - On `rsp_valid & rsp_ready`: go to `IDLE`, unless `CMP_ARB_PIPE_EN` is defined (see Configuration).
- Datapath, in sub-module `cmp_core`:
  - LUI: `r = {b[15:0],16'h0}`.
  - SLT/SLTU: `r = {31'b0, lt}`.
  - `eq` and `lt` are computed for every operation, including LUI.
  - Signed compare is two's complement: 0x80000000 < 0x7FFFFFFF when signed, and greater when unsigned.
- Only the granted requester's operands pass through the mux into `cmp_core`. Operands are sampled only on the transfer edge.
- A requester must hold its valid and operands until it is granted. The block does not check for a requester withdrawing a request.

## Timing
- Reset values:
  - State `IDLE`; `last_grant`=1, so requester 0 wins the first contention.
  - `req_ready`=0, `rsp_valid`=0, `rsp_r`=0, `rsp_eq`=0, `rsp_lt`=0, `rsp_id`=0.
- Latency: a request accepted on edge N gives `rsp_valid`=1 in the cycle after edge N.
- `req_ready` is combinational from `req_valid`, state and `last_grant`. It never depends on the operand values.
- All response outputs come directly from flops. There are no combinational paths from the request ports to the response ports.
- Throughput without the macro: at most one request every 2 cycles.
- Fairness: under continuous contention, grants alternate 0,1,0,1. A requester waits at most 1 response cycle plus 1 cycle per other grant.
- Reset asserted mid-operation: asynchronously returns every output to its reset value and discards any held result. No response is issued for it.

## Configuration
- `CMP_ARB_PIPE_EN` defined:
  - In `BUSY` with `rsp_ready`=1, the arbiter also grants per the `IDLE` rule in the same cycle.
  - On a grant in that cycle, the response registers load the new result and the state stays `BUSY`.
  - This gives back-to-back responses and 1 request per cycle.
- `CMP_ARB_PIPE_EN` undefined:
  - `req_ready`=0 in all of `BUSY`.

## Structure
- Package `cmp_arb_pkg`:
  - ALUC encodings: `ALUC_LUI`=2'b00, `ALUC_SLTU`=2'b10, `ALUC_SLT`=2'b11.
  - State enum: `IDLE`, `BUSY`.
  - Requester ID constants: `REQ_EXE`=0, `REQ_BR`=1.
- Sub-module `cmp_core`: purely combinational.
  - Ports: a, b, aluc → r, eq, lt.
  - Reusable as the ALU's compare slice.
- The arbiter, handshake logic and response registers live in `cmp_arbiter`.

## Test plan
- Reset, then a single request: requester 0 sends a=0, b=0x00001234, aluc=00 → next cycle `rsp_valid`=1, `rsp_r`=0x12340000, `rsp_id`=0.
- Signed vs unsigned: requester 1 sends a=0x80000000, b=0x7FFFFFFF with aluc=11 → r=1, lt=1. The same operands with aluc=10 → r=0, lt=0, eq=0.
- Contention: both requesters valid for 4 transfers, `rsp_ready` held at 1 → `rsp_id` sequence 0,1,0,1. With the macro undefined, `req_ready` is 0 in every `BUSY` cycle.
- Backpressure: `rsp_ready`=0 for 5 cycles with a=b=5 → `rsp_r`=0, `rsp_eq`=1, all response outputs stable, `req_ready`=0 throughout.
- Reset mid-operation: assert `rst_n` low while in `BUSY` → `rsp_valid` drops without waiting for a clock. After release, the first contention grants requester 0.
- With `CMP_ARB_PIPE_EN`: requester 0 issues continuously with `rsp_ready`=1 → `rsp_valid` stays 1 on consecutive cycles with the correct results.
